// File: rtl/alu_control_issuer.sv
// Multicycle sequencer that drives the ALU control decoder's controlType bus for one
// decoded instruction, waits on the divider/multiplier and reports done or exception.
module alu_control_issuer #(
  parameter int MAX_WAIT = 48
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       div_done,
  input  logic       mult_done,
  input  logic       div_zero,
  output logic [4:0] controlType,
  output logic       busy,
  output logic       done,
  output logic       exc,
  output logic [1:0] exc_cause
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [4:0] CODE_IDLE = 5'd13;
  localparam logic [4:0] CODE_DIV  = 5'd9;
  localparam logic [4:0] CODE_MULT = 5'd10;

  localparam logic [1:0] CAUSE_OVF   = 2'b01;
  localparam logic [1:0] CAUSE_ILL   = 2'b10;
  localparam logic [1:0] CAUSE_FAULT = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [4:0]    ctrl_q, ctrl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          exc_q, exc_d;
  logic [1:0]    cause_q, cause_d;

  logic [4:0] dec_code;
  logic       dec_legal;
  logic       code_checked;

  always_comb begin
    dec_code  = CODE_IDLE;
    dec_legal = 1'b1;
    if (opcode == 6'h00) begin
      case (funct)
        6'h20:   dec_code = 5'd1;
        6'h22:   dec_code = 5'd2;
        6'h24:   dec_code = 5'd3;
        6'h25:   dec_code = 5'd8;
        6'h21:   dec_code = 5'd11;
        6'h2A:   dec_code = 5'd7;
        6'h1A:   dec_code = CODE_DIV;
        6'h18:   dec_code = CODE_MULT;
        default: dec_legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'h08:   dec_code = 5'd1;
        6'h09:   dec_code = 5'd11;
        6'h0C:   dec_code = 5'd3;
        6'h0A:   dec_code = 5'd7;
        6'h0F:   dec_code = 5'd12;
        6'h04:   dec_code = 5'd14;
        6'h05:   dec_code = 5'd15;
        6'h06:   dec_code = 5'd16;
        6'h07:   dec_code = 5'd17;
        default: dec_legal = 1'b0;
      endcase
    end
  end

  assign code_checked = (ctrl_q == 5'd1) || (ctrl_q == 5'd2) || (ctrl_q == 5'd4);

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    exc_d   = 1'b0;
    cause_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dec_legal) begin
            state_d = S_EXEC;
            ctrl_d  = dec_code;
            cnt_d   = CW'(1);
          end else begin
            state_d = S_RESP;
            exc_d   = 1'b1;
            cause_d = CAUSE_ILL;
          end
        end
      end
      S_EXEC: begin
        if (ctrl_q == CODE_DIV || ctrl_q == CODE_MULT) begin
          // Zero check outranks completion, completion outranks timeout on the last cycle
          if (ctrl_q == CODE_DIV && div_zero) begin
            exc_d   = 1'b1;
            cause_d = CAUSE_FAULT;
          end else if ((ctrl_q == CODE_DIV) ? div_done : mult_done) begin
            done_d = 1'b1;
          end else if (cnt_q == CW'(MAX_WAIT)) begin
            exc_d   = 1'b1;
            cause_d = CAUSE_FAULT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (code_checked && overflow) begin
          exc_d   = 1'b1;
          cause_d = CAUSE_OVF;
        end else begin
          done_d = 1'b1;
        end
        if (done_d || exc_d) begin
          state_d = S_RESP;
          ctrl_d  = CODE_IDLE;
          cnt_d   = '0;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        ctrl_d  = CODE_IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= CODE_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      exc_q   <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      exc_q   <= exc_d;
      cause_q <= cause_d;
    end
  end

  assign controlType = ctrl_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign exc         = exc_q;
  assign exc_cause   = cause_q;
endmodule

// File: tb/tb_alu_control_issuer.sv
// Directed plus randomized bench for alu_control_issuer against a transaction-level
// reference model (expected code, EXEC length and outcome per instruction).
module tb_alu_control_issuer;
  localparam int MAX_WAIT = 48;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       overflow;
  logic       div_done;
  logic       mult_done;
  logic       div_zero;
  logic [4:0] controlType;
  logic       busy;
  logic       done;
  logic       exc;
  logic [1:0] exc_cause;

  int checks = 0;
  int errors = 0;

  alu_control_issuer #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode), .funct(funct),
    .overflow(overflow), .div_done(div_done), .mult_done(mult_done), .div_zero(div_zero),
    .controlType(controlType), .busy(busy), .done(done), .exc(exc), .exc_cause(exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction table: opcode/funct pairs and the code each must produce.
  int r_funct[8] = '{'h20, 'h22, 'h24, 'h25, 'h21, 'h2A, 'h1A, 'h18};
  int r_code[8]  = '{1, 2, 3, 8, 11, 7, 9, 10};
  int i_op[9]    = '{'h08, 'h09, 'h0C, 'h0A, 'h0F, 'h04, 'h05, 'h06, 'h07};
  int i_code[9]  = '{1, 11, 3, 7, 12, 14, 15, 16, 17};

  function automatic int ref_code(input logic [5:0] op, input logic [5:0] fn);
    int code = -1;
    if (op == 6'h00) begin
      for (int i = 0; i < 8; i++) if (int'(fn) == r_funct[i]) code = r_code[i];
    end else begin
      for (int i = 0; i < 9; i++) if (int'(op) == i_op[i]) code = i_code[i];
    end
    return code;
  endfunction

  // One instruction from an IDLE cycle (entered #1 after a rising edge) to the next IDLE cycle.
  // done_cyc/zero_cyc give the 1-based EXEC cycle in which the unit flag is raised (0 = never).
  task automatic run_op(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                        input int done_cyc, input int zero_cyc, input logic busy_start);
    int code, len;
    logic ok, long_op;
    logic [1:0] cause;
    code = ref_code(op, fn);
    start = 1'b1; opcode = op; funct = fn; overflow = ovf;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_ctrl", 32'(controlType), 13);
    @(posedge clk); #1;
    start = 1'b0; opcode = 6'($urandom); funct = 6'($urandom);
    if (code < 0) begin
      @(negedge clk);
      check("ill_exc", 32'(exc), 1);
      check("ill_cause", 32'(exc_cause), 2);
      check("ill_done", 32'(done), 0);
      check("ill_ctrl", 32'(controlType), 13);
      @(posedge clk); #1;
      $display("op=%h fn=%h illegal -> exc cause 2", op, fn);
      return;
    end
    long_op = (code == 9 || code == 10);
    if (!long_op) begin
      len = 1;
      ok = !((code == 1 || code == 2 || code == 4) && ovf);
      cause = ok ? 2'b00 : 2'b01;
    end else begin
      len = MAX_WAIT; ok = 1'b0; cause = 2'b11;
      for (int c = 1; c <= MAX_WAIT; c++) begin
        if (code == 9 && c == zero_cyc) begin len = c; break; end
        if (c == done_cyc) begin len = c; ok = 1'b1; cause = 2'b00; break; end
      end
    end
    for (int c = 1; c <= len; c++) begin
      start = busy_start;
      if (busy_start) begin opcode = 6'h08; funct = 6'($urandom); end
      div_done  = (code == 9)  ? (c == done_cyc) : 1'($urandom);
      mult_done = (code == 10) ? (c == done_cyc) : 1'($urandom);
      div_zero  = (code == 9)  ? (c == zero_cyc) : 1'($urandom);
      overflow  = long_op ? 1'($urandom) : ovf;
      @(negedge clk);
      check("exec_ctrl", 32'(controlType), 32'(code));
      check("exec_busy", 32'(busy), 1);
      check("exec_nopulse", 32'({done, exc}), 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    div_done = 1'($urandom); mult_done = 1'($urandom); div_zero = 1'($urandom);
    @(negedge clk);
    check("resp_ctrl", 32'(controlType), 13);
    check("resp_done", 32'(done), 32'(ok));
    check("resp_exc", 32'(exc), 32'(!ok));
    check("resp_cause", 32'(exc_cause), 32'(cause));
    check("resp_busy", 32'(busy), 1);
    @(posedge clk); #1;
    $display("op=%h fn=%h code=%0d exec_cycles=%0d %s cause=%0d", op, fn, code, len,
             ok ? "done" : "exc", cause);
  endtask

  initial begin
    int r, dc, zc;
    logic [5:0] op, fn;
    reset_n = 1'b0; start = 1'b0; opcode = '0; funct = '0; overflow = 1'b0;
    div_done = 1'b0; mult_done = 1'b0; div_zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", 32'(controlType), 13);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", 32'({done, exc}), 0);
    check("rst_cause", 32'(exc_cause), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);        // add, no overflow
    run_op(6'h00, 6'h20, 1'b1, 0, 0, 1'b0);        // add, overflow -> cause 01
    run_op(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);        // beq, overflow ignored
    run_op(6'h07, 6'h00, 1'b0, 0, 0, 1'b0);        // bgt back-to-back
    run_op(6'h00, 6'h1A, 1'b0, 5, 0, 1'b0);        // div done in cycle 5
    run_op(6'h00, 6'h1A, 1'b0, 2, 2, 1'b0);        // div zero beats done
    run_op(6'h00, 6'h18, 1'b0, 0, 0, 1'b0);        // mult timeout
    run_op(6'h00, 6'h18, 1'b0, MAX_WAIT, 0, 1'b0); // mult done on last cycle
    run_op(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);        // illegal opcode
    run_op(6'h00, 6'h1A, 1'b0, 7, 0, 1'b1);        // start while busy ignored

    // Reset in EXEC cycle 10 of a mult abandons it without a pulse.
    start = 1'b1; opcode = 6'h00; funct = 6'h18; mult_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c < 10) begin @(posedge clk); #1; end
    end
    check("mid_ctrl", 32'(controlType), 10);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ctrl", 32'(controlType), 13);
    check("arst_busy", 32'(busy), 0);
    check("arst_pulses", 32'({done, exc}), 0);
    @(posedge clk); #1;
    check("arst_hold", 32'({busy, done, exc}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    $display("reset during mult: abandoned");
    run_op(6'h08, 6'h00, 1'b0, 0, 0, 1'b0);        // addi after reset

    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        op = 6'h00;
        fn = (r == 3) ? 6'($urandom) : 6'(r_funct[$urandom_range(0, 7)]);
      end else if (r < 8) begin
        op = 6'(i_op[$urandom_range(0, 8)]);
        fn = 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      dc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAX_WAIT + 4))
                                       : int'($urandom_range(1, 8));
      zc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_op(op, fn, 1'($urandom), dc, zc, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
